// File: rtl/boundary_detect.sv
// Per-frame bounding box of dark (digit) pixels inside a margin-trimmed active area.
// The box is published one cycle after the last pixel of the frame, together with a frame_done pulse.
module boundary_detect #(
    parameter int         H_ACTIVE = 320,
    parameter int         V_ACTIVE = 240,
    parameter logic [7:0] THRESH   = 8'd128,
    parameter int         MARGIN   = 4,
    parameter int         MIN_PIX  = 32
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       wren,
    input  logic       tft_begin,
    input  logic [7:0] data_in,
    input  logic [8:0] hcount,
    input  logic [8:0] lcount,
    output logic [8:0] Upper_data,
    output logic [8:0] Lower_data,
    output logic [8:0] Lift_data,
    output logic [8:0] Right_data,
    output logic       box_valid,
    output logic       frame_done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, LATCH = 2'd2} state_t;

    localparam logic [8:0]  H_LO    = 9'(MARGIN);
    localparam logic [8:0]  H_HI    = 9'(H_ACTIVE - MARGIN);
    localparam logic [8:0]  V_LO    = 9'(MARGIN);
    localparam logic [8:0]  V_HI    = 9'(V_ACTIVE - MARGIN);
    localparam logic [8:0]  H_LAST  = 9'(H_ACTIVE - 1);
    localparam logic [8:0]  V_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [16:0] MIN_CNT = 17'(MIN_PIX);

    state_t      state_q, state_d;
    logic [8:0]  min_row_q, min_row_d, max_row_q, max_row_d;
    logic [8:0]  min_col_q, min_col_d, max_col_q, max_col_d;
    logic [16:0] count_q, count_d;
    logic [8:0]  upper_q, upper_d, lower_q, lower_d, lift_q, lift_d, right_q, right_d;
    logic        box_valid_q, box_valid_d, frame_done_q, frame_done_d;
    logic        in_area, last_pix, pix_ok, init_acc;

    // wren qualifies the pixel on hcount/lcount/data_in for one cycle; there is no back-pressure.
    assign in_area  = (hcount >= H_LO) && (hcount < H_HI) && (lcount >= V_LO) && (lcount < V_HI);
    assign last_pix = wren && (hcount == H_LAST) && (lcount == V_LAST);
    assign pix_ok   = (state_q == SCAN) && wren && (data_in < THRESH) && in_area;

    always_comb begin
        state_d  = state_q;
        init_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (tft_begin) begin
                    state_d  = SCAN;
                    init_acc = 1'b1;
                end
            end
            SCAN: begin
                // A new frame start overrides everything, including the last pixel.
                if (tft_begin) begin
                    init_acc = 1'b1;
                end else if (last_pix) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d  = tft_begin ? SCAN : IDLE;
                init_acc = tft_begin;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        min_row_d = min_row_q;
        max_row_d = max_row_q;
        min_col_d = min_col_q;
        max_col_d = max_col_q;
        count_d   = count_q;
        if (init_acc) begin
            min_row_d = 9'h1FF;
            max_row_d = 9'h000;
            min_col_d = 9'h1FF;
            max_col_d = 9'h000;
            count_d   = '0;
        end else if (pix_ok) begin
            if (lcount < min_row_q) min_row_d = lcount;
            if (lcount > max_row_q) max_row_d = lcount;
            if (hcount < min_col_q) min_col_d = hcount;
            if (hcount > max_col_q) max_col_d = hcount;
            if (count_q != '1) count_d = count_q + 17'd1;
        end
    end

    always_comb begin
        upper_d      = upper_q;
        lower_d      = lower_q;
        lift_d       = lift_q;
        right_d      = right_q;
        box_valid_d  = box_valid_q;
        frame_done_d = 1'b0;
        if (state_q == LATCH) begin
            frame_done_d = 1'b1;
            box_valid_d  = (count_q >= MIN_CNT);
            if (count_q >= MIN_CNT) begin
                upper_d = min_row_q;
                lower_d = max_row_q;
                lift_d  = min_col_q;
                right_d = max_col_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            min_row_q    <= '0;
            max_row_q    <= '0;
            min_col_q    <= '0;
            max_col_q    <= '0;
            count_q      <= '0;
            upper_q      <= '0;
            lower_q      <= '0;
            lift_q       <= '0;
            right_q      <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_row_q    <= min_row_d;
            max_row_q    <= max_row_d;
            min_col_q    <= min_col_d;
            max_col_q    <= max_col_d;
            count_q      <= count_d;
            upper_q      <= upper_d;
            lower_q      <= lower_d;
            lift_q       <= lift_d;
            right_q      <= right_d;
            box_valid_q  <= box_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Upper_data = upper_q;
    assign Lower_data = lower_q;
    assign Lift_data  = lift_q;
    assign Right_data = right_q;
    assign box_valid  = box_valid_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_boundary_detect.sv
// Bench for boundary_detect: sparse frames (only the pixels of interest plus the last pixel),
// expected boxes queued as each frame is driven and compared when frame_done appears.
module tb_boundary_detect;

    localparam int H    = 320;
    localparam int V    = 240;
    localparam int MARG = 4;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       wren = 1'b0;
    logic       tft_begin = 1'b0;
    logic [7:0] data_in = 8'hFF;
    logic [8:0] hcount = '0;
    logic [8:0] lcount = '0;
    logic [8:0] Upper_data, Lower_data, Lift_data, Right_data;
    logic       box_valid, frame_done;
    logic [1:0] dbg_state;

    int tests_run = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [36:0] exp_q[$];

    boundary_detect dut (
        .clock(clock), .rst(rst), .wren(wren), .tft_begin(tft_begin),
        .data_in(data_in), .hcount(hcount), .lcount(lcount),
        .Upper_data(Upper_data), .Lower_data(Lower_data),
        .Lift_data(Lift_data), .Right_data(Right_data),
        .box_valid(box_valid), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (frame_done === 1'b1) done_cnt++;

    function automatic logic [36:0] obs();
        return {box_valid, Upper_data, Lower_data, Lift_data, Right_data};
    endfunction

    function automatic logic [36:0] box(input logic v, input int u, input int lo, input int le, input int r);
        return {v, 9'(u), 9'(lo), 9'(le), 9'(r)};
    endfunction

    task automatic pix(input int h, input int l, input int d);
        @(negedge clock);
        tft_begin = 1'b0;
        wren      = 1'b1;
        hcount    = 9'(h);
        lcount    = 9'(l);
        data_in   = 8'(d);
    endtask

    task automatic begin_frame();
        @(negedge clock);
        tft_begin = 1'b1;
        wren      = 1'b0;
    endtask

    task automatic end_frame();
        pix(H - 1, V - 1, 255);
    endtask

    task automatic white_pix();
        pix(int'($urandom_range(MARG, H - MARG - 1)), int'($urandom_range(MARG, V - MARG - 1)),
            int'($urandom_range(128, 255)));
    endtask

    // Black rectangle, interleaved with white pixels and with dark pixels that have wren low.
    task automatic black_rect(input int r0, input int r1, input int c0, input int c1);
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                pix(c, r, int'($urandom_range(0, 127)));
                if ($urandom_range(0, 3) == 0) white_pix();
                if ($urandom_range(0, 7) == 0) begin
                    @(negedge clock);
                    wren    = 1'b0;
                    hcount  = 9'(MARG);
                    lcount  = 9'(V - MARG - 1);
                    data_in = 8'h00;
                end
            end
        end
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            wren      = 1'b0;
            tft_begin = 1'b0;
            if (frame_done === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic pop_exp(output logic [36:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if (obs() !== 37'd0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %h/%b required 0/0", obs(), frame_done);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
        rst = 1'b0;
        black_rect(60, 63, 60, 69);
        end_frame();
        wait_done(k);
        tests_run++;
        if (k !== -1 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL ignore_before_begin: done_at %0d state %0d required -1/0", k, dbg_state);
        end
    endtask

    task automatic test_rect();
        int k;
        logic [36:0] e;
        begin_frame();
        pix(H - MARG, 120, 0);
        pix(150, V - MARG, 0);
        pix(MARG - 1, 120, 0);
        pix(160, MARG - 1, 0);
        black_rect(100, 139, 150, 179);
        exp_q.push_back(box(1'b1, 100, 139, 150, 179));
        end_frame();
        wait_done(k);
        tests_run++;
        if (k !== 2) begin
            fails++;
            $display("FAIL rect_latency: frame_done after %0d cycles required 2", k);
        end
        pop_exp(e);
        tests_run++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL rect_box: got %h required %h", obs(), e);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL rect_idle: state %0d required 0", dbg_state);
        end
        @(negedge clock);
        tests_run++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("FAIL rect_pulse_width: frame_done %b required 0", frame_done);
        end
    endtask

    // Generic single frame: frame body already driven by caller; checks latency and box.
    task automatic test_frame_check(input string name);
        int k;
        logic [36:0] e;
        end_frame();
        wait_done(k);
        pop_exp(e);
        tests_run++;
        if (k !== 2 || obs() !== e) begin
            fails++;
            $display("FAIL %s: done_at %0d box %h required 2 %h", name, k, obs(), e);
        end
    endtask

    task automatic test_white();
        begin_frame();
        pix(200, 120, 128);
        repeat (200) white_pix();
        exp_q.push_back(box(1'b0, 100, 139, 150, 179));
        test_frame_check("white_frame");
    endtask

    task automatic test_margin();
        begin_frame();
        pix(2, 2, 0);
        black_rect(50, 51, 60, 79);
        exp_q.push_back(box(1'b1, 50, 51, 60, 79));
        test_frame_check("margin_pixel");
    endtask

    task automatic test_small();
        begin_frame();
        black_rect(30, 34, 30, 34);
        exp_q.push_back(box(1'b0, 50, 51, 60, 79));
        test_frame_check("small_blob");
    endtask

    task automatic test_edges();
        begin_frame();
        pix(MARG, MARG, 0);
        pix(H - MARG - 1, V - MARG - 1, 127);
        black_rect(100, 100, 100, 129);
        exp_q.push_back(box(1'b1, MARG, V - MARG - 1, MARG, H - MARG - 1));
        test_frame_check("area_edges");
    endtask

    task automatic test_minpix();
        begin_frame();
        black_rect(70, 70, 70, 100);
        exp_q.push_back(box(1'b0, MARG, V - MARG - 1, MARG, H - MARG - 1));
        test_frame_check("count_31");
        begin_frame();
        black_rect(80, 80, 70, 101);
        exp_q.push_back(box(1'b1, 80, 80, 70, 101));
        test_frame_check("count_32");
    endtask

    task automatic test_restart();
        int snap;
        begin_frame();
        black_rect(10, 20, 100, 110);
        for (int l = 21; l < 120; l += 9) pix(50, l, 200);
        @(negedge clock);
        tft_begin = 1'b1;
        wren      = 1'b1;
        hcount    = 9'd50;
        lcount    = 9'd120;
        data_in   = 8'h00;
        snap = done_cnt;
        black_rect(200, 210, 40, 45);
        exp_q.push_back(box(1'b1, 200, 210, 40, 45));
        test_frame_check("restart_mid_scan");
        repeat (3) @(negedge clock);
        tests_run++;
        if (done_cnt - snap !== 1) begin
            fails++;
            $display("FAIL restart_single_done: %0d pulses required 1", done_cnt - snap);
        end
    endtask

    task automatic test_last_begin();
        int k;
        begin_frame();
        black_rect(150, 155, 150, 155);
        @(negedge clock);
        tft_begin = 1'b1;
        wren      = 1'b1;
        hcount    = 9'(H - 1);
        lcount    = 9'(V - 1);
        data_in   = 8'hFF;
        wait_done(k);
        tests_run++;
        if (k !== -1 || dbg_state !== 2'd1) begin
            fails++;
            $display("FAIL begin_on_last: done_at %0d state %0d required -1/1", k, dbg_state);
        end
        black_rect(5, 6, 10, 29);
        exp_q.push_back(box(1'b1, 5, 6, 10, 29));
        test_frame_check("after_begin_on_last");
    endtask

    task automatic test_back_to_back();
        logic [36:0] e;
        begin_frame();
        black_rect(60, 61, 100, 119);
        exp_q.push_back(box(1'b1, 60, 61, 100, 119));
        end_frame();
        @(negedge clock);
        tft_begin = 1'b1;
        wren      = 1'b0;
        @(negedge clock);
        tft_begin = 1'b0;
        pop_exp(e);
        tests_run++;
        if (frame_done !== 1'b1 || obs() !== e) begin
            fails++;
            $display("FAIL b2b_first: done %b box %h required 1 %h", frame_done, obs(), e);
        end
        tests_run++;
        if (dbg_state !== 2'd1) begin
            fails++;
            $display("FAIL b2b_rescan: state %0d required 1", dbg_state);
        end
        black_rect(90, 91, 20, 39);
        exp_q.push_back(box(1'b1, 90, 91, 20, 39));
        test_frame_check("b2b_second");
    endtask

    task automatic test_midreset();
        int k;
        begin_frame();
        black_rect(100, 110, 100, 110);
        @(negedge clock);
        rst  = 1'b1;
        wren = 1'b0;
        @(negedge clock);
        rst = 1'b0;
        tests_run++;
        if (obs() !== 37'd0 || frame_done !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL midreset_clear: box %h done %b state %0d required 0", obs(), frame_done, dbg_state);
        end
        black_rect(30, 31, 30, 49);
        end_frame();
        wait_done(k);
        tests_run++;
        if (k !== -1) begin
            fails++;
            $display("FAIL midreset_no_done: done_at %0d required -1", k);
        end
        begin_frame();
        black_rect(120, 121, 130, 149);
        exp_q.push_back(box(1'b1, 120, 121, 130, 149));
        test_frame_check("midreset_next_frame");
    endtask

    initial begin
        test_reset();
        test_rect();
        test_white();
        test_margin();
        test_small();
        test_edges();
        test_minpix();
        test_restart();
        test_last_begin();
        test_back_to_back();
        test_midreset();
        repeat (4) @(negedge clock);
        tests_run++;
        if (done_cnt !== 12 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL done_total: %0d pulses %0d left required 12 0", done_cnt, exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
